// File: rtl/program_loader.sv
// Framed byte-stream loader that writes 32-bit instruction words into instruction RAM and stalls the cpu until done.
// Optional feature macro: LOADER_CHECKSUM_EN (frame ends with an XOR checksum byte; a mismatch ends in ERROR).
module program_loader #(
    parameter int         ADDR_WIDTH = 8,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    input  logic                  reload,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wr_data,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error,
    output logic [2:0]            debug_state
);

    // One extra bit so a count of 2**ADDR_WIDTH words is representable.
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0] CNT_FULL = CNT_ONE << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_CSUM  = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  xfer;
    logic [ADDR_WIDTH:0]   word_cnt;
    logic [ADDR_WIDTH:0]   word_total;
    logic [ADDR_WIDTH:0]   word_cnt_inc;
    logic                  last_word;
    logic [1:0]            byte_idx;
    logic [23:0]           shift;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            checksum;
`endif

    assign word_cnt_inc = word_cnt + CNT_ONE;
    assign last_word    = (word_cnt_inc == word_total);
    assign debug_state  = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Stream handshake: a byte moves only on a rising edge where byte_valid and
    // byte_ready are both high; byte_ready depends on state alone, never on byte_valid.
    always_comb begin
        byte_ready = 1'b0;
        mem_wr_en  = 1'b0;
        cpu_hold   = 1'b1;
        load_done  = 1'b0;
        load_error = 1'b0;
        state_nxt  = state;

        case (state)
            S_IDLE, S_LEN, S_DATA: byte_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            S_CSUM:                byte_ready = 1'b1;
            S_ERROR:               load_error = 1'b1;
`endif
            S_WRITE:               mem_wr_en  = 1'b1;
            S_DONE: begin
                cpu_hold  = 1'b0;
                load_done = 1'b1;
            end
            default: ;
        endcase

        xfer = byte_valid & byte_ready;

        case (state)
            S_IDLE: begin
                if (xfer && byte_in == SYNC_BYTE) state_nxt = S_LEN;
            end
            S_LEN: begin
                if (xfer) state_nxt = S_DATA;
            end
            S_DATA: begin
                if (xfer && byte_idx == 2'd3) state_nxt = S_WRITE;
            end
            S_WRITE: begin
`ifdef LOADER_CHECKSUM_EN
                state_nxt = last_word ? S_CSUM : S_DATA;
`else
                state_nxt = last_word ? S_DONE : S_DATA;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (xfer) state_nxt = (byte_in == checksum) ? S_DONE : S_ERROR;
            end
            S_ERROR: begin
                if (reload) state_nxt = S_IDLE;
            end
`endif
            S_DONE: begin
                if (reload) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Word assembly; mem_addr/mem_wr_data are loaded with the 4th byte so they
    // are stable throughout WRITE and keep their value afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_cnt    <= '0;
            word_total  <= '0;
            byte_idx    <= 2'd0;
            shift       <= 24'd0;
            mem_addr    <= '0;
            mem_wr_data <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
            checksum    <= 8'd0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (xfer && byte_in == SYNC_BYTE) begin
                        word_cnt <= '0;
                        byte_idx <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
                        checksum <= 8'd0;
`endif
                    end
                end
                S_LEN: begin
                    if (xfer) begin
                        word_total <= (byte_in == 8'd0) ? CNT_FULL : (ADDR_WIDTH + 1)'(byte_in);
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        byte_idx <= byte_idx + 2'd1;
                        shift    <= {shift[15:0], byte_in};
`ifdef LOADER_CHECKSUM_EN
                        checksum <= checksum ^ byte_in;
`endif
                        if (byte_idx == 2'd3) begin
                            mem_addr    <= word_cnt[ADDR_WIDTH-1:0];
                            mem_wr_data <= {shift, byte_in};
                        end
                    end
                end
                S_WRITE: begin
                    word_cnt <= word_cnt_inc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader; follows LOADER_CHECKSUM_EN to decide whether frames carry a checksum.
module tb_program_loader;

    localparam int         AW       = 8;
    localparam logic [7:0] SYNC     = 8'hA5;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DONE  = 3'd5;
    localparam logic [2:0] ST_ERROR = 3'd6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    byte_in = 8'd0;
    logic          byte_valid = 1'b0;
    logic          byte_ready;
    logic          reload = 1'b0;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wr_data;
    logic          cpu_hold;
    logic          load_done;
    logic          load_error;
    logic [2:0]    debug_state;

    program_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(SYNC)) dut (
        .clk         (clk),
        .reset       (reset),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .reload      (reload),
        .mem_wr_en   (mem_wr_en),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .cpu_hold    (cpu_hold),
        .load_done   (load_done),
        .load_error  (load_error),
        .debug_state (debug_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int            errors = 0;
    int            checks = 0;
    int            last_acc_cyc = 0;
    logic [31:0]   tx_words[$];
    logic [31:0]   exp_q[$];
    int            acc_q[$];
    logic [AW-1:0] wr_addr_q[$];
    logic [31:0]   wr_data_q[$];
    int            wr_cyc_q[$];
    logic          wr_rdy_q[$];
    logic          wr_done_q[$];

    always @(negedge clk) begin
        if (mem_wr_en === 1'b1) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wr_data);
            wr_cyc_q.push_back(cyc);
            wr_rdy_q.push_back(byte_ready);
            wr_done_q.push_back(load_done);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        wr_rdy_q.delete();
        wr_done_q.delete();
        exp_q.delete();
        acc_q.delete();
    endtask

    task automatic apply_reset();
        byte_valid = 1'b0;
        reload     = 1'b0;
        reset      = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waits = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (byte_ready !== 1'b1 && waits < 50) begin
            @(posedge clk);
            #1;
            waits++;
        end
        if (byte_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_byte_timeout: byte_ready=%b required 1", byte_ready);
        end
        @(posedge clk);
        #1;
        last_acc_cyc = cyc;
    endtask

    task automatic idle_bus();
        byte_valid = 1'b0;
        byte_in    = 8'd0;
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        while (load_done !== 1'b1 && load_error !== 1'b1 && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    function automatic logic [7:0] words_xor();
        logic [7:0] x;
        x = 8'h00;
        foreach (tx_words[i]) x = x ^ tx_words[i][31:24] ^ tx_words[i][23:16] ^ tx_words[i][15:8] ^ tx_words[i][7:0];
        return x;
    endfunction
`endif

    task automatic send_frame(input logic [7:0] n_byte);
        logic [31:0] w;
        send_byte(SYNC);
        send_byte(n_byte);
        foreach (tx_words[i]) begin
            w = tx_words[i];
            for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8]);
            acc_q.push_back(last_acc_cyc);
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(words_xor());
`endif
        idle_bus();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        checks++;
        if ({byte_ready, mem_wr_en, cpu_hold, load_done, load_error} !== 5'b10100) begin
            errors++;
            $display("FAIL reset_flags: got %b want 10100", {byte_ready, mem_wr_en, cpu_hold, load_done, load_error});
        end
        checks++;
        if (mem_addr !== 8'd0) begin
            errors++;
            $display("FAIL reset_mem_addr: got %h want 00", mem_addr);
        end
        checks++;
        if (mem_wr_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_mem_wr_data: got %h want 00000000", mem_wr_data);
        end
        checks++;
        if (debug_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d want %0d", debug_state, ST_IDLE);
        end
    endtask

    task automatic test_single_word();
        clear_mon();
        tx_words = '{32'h12345678};
        exp_q    = tx_words;
        send_frame(8'd1);
        wait_end(20);
        checks++;
        if (wr_data_q.size() != 1) begin
            errors++;
            $display("FAIL single_write_count: got %0d want 1", wr_data_q.size());
        end
        if (wr_data_q.size() >= 1) begin
            checks++;
            if (wr_addr_q[0] !== 8'd0 || wr_data_q[0] !== exp_q[0]) begin
                errors++;
                $display("FAIL single_write: got addr %h data %h want addr 00 data %h", wr_addr_q[0], wr_data_q[0], exp_q[0]);
            end
        end
        checks++;
        if ({load_done, cpu_hold, load_error} !== 3'b100) begin
            errors++;
            $display("FAIL single_done_flags: done/hold/err got %b want 100", {load_done, cpu_hold, load_error});
        end
        do_reload();
        checks++;
        if ({cpu_hold, load_done, debug_state} !== {1'b1, 1'b0, ST_IDLE}) begin
            errors++;
            $display("FAIL single_reload: hold/done/state got %b/%b/%0d want 1/0/%0d", cpu_hold, load_done, debug_state, ST_IDLE);
        end
    endtask

    task automatic test_discard_latency();
        logic [31:0] w;
        clear_mon();
        tx_words = '{32'h01020304, 32'hA5A5A5A5};
        exp_q    = tx_words;
        send_byte(8'h00);
        send_byte(8'hFF);
        checks++;
        if (debug_state !== ST_IDLE) begin
            errors++;
            $display("FAIL discard_state: got %0d want %0d", debug_state, ST_IDLE);
        end
        send_byte(SYNC);
        send_byte(8'd2);
        foreach (tx_words[i]) begin
            w = tx_words[i];
            for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8]);
            acc_q.push_back(last_acc_cyc);
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h04);
`endif
        idle_bus();
        wait_end(20);
        checks++;
        if (wr_data_q.size() != 2) begin
            errors++;
            $display("FAIL discard_write_count: got %0d want 2", wr_data_q.size());
        end
        for (int i = 0; i < 2 && i < wr_data_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] !== i[7:0] || wr_data_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL discard_write_%0d: got addr %h data %h want addr %h data %h", i, wr_addr_q[i], wr_data_q[i], i[7:0], exp_q[i]);
            end
            checks++;
            if (wr_cyc_q[i] != acc_q[i] || wr_rdy_q[i] !== 1'b0) begin
                errors++;
                $display("FAIL discard_latency_%0d: write cycle %0d ready %b want cycle %0d ready 0", i, wr_cyc_q[i], wr_rdy_q[i], acc_q[i]);
            end
        end
        checks++;
        if (load_done !== 1'b1) begin
            errors++;
            $display("FAIL discard_done: got %b want 1", load_done);
        end
        do_reload();
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum_error();
        logic [7:0] bytes[7];
        clear_mon();
        bytes = '{8'hA5, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
        foreach (bytes[i]) send_byte(bytes[i]);
        idle_bus();
        wait_end(20);
        checks++;
        if (wr_data_q.size() != 1 || (wr_data_q.size() == 1 && wr_data_q[0] !== 32'h11223344)) begin
            errors++;
            $display("FAIL csum_write: count %0d want 1 with data 11223344", wr_data_q.size());
        end
        checks++;
        if ({load_error, cpu_hold, load_done, byte_ready} !== 4'b1100 || debug_state !== ST_ERROR) begin
            errors++;
            $display("FAIL csum_error_flags: err/hold/done/ready got %b state %0d want 1100 state %0d",
                     {load_error, cpu_hold, load_done, byte_ready}, debug_state, ST_ERROR);
        end
        do_reload();
        checks++;
        if (load_error !== 1'b0 || debug_state !== ST_IDLE) begin
            errors++;
            $display("FAIL csum_reload: err %b state %0d want 0 state %0d", load_error, debug_state, ST_IDLE);
        end
    endtask
`endif

    task automatic test_full_256();
        logic [7:0] a;
        int         early;
        clear_mon();
        tx_words.delete();
        for (int i = 0; i < 256; i++) begin
            a = i[7:0];
            tx_words.push_back({a, ~a, a ^ 8'h3C, 8'h5A});
        end
        exp_q = tx_words;
        send_frame(8'd0);
        wait_end(40);
        checks++;
        if (wr_data_q.size() != 256) begin
            errors++;
            $display("FAIL full_write_count: got %0d want 256", wr_data_q.size());
        end
        early = 0;
        for (int i = 0; i < 256 && i < wr_data_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] !== i[7:0] || wr_data_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL full_write_%0d: got addr %h data %h want addr %h data %h", i, wr_addr_q[i], wr_data_q[i], i[7:0], exp_q[i]);
            end
            if (wr_done_q[i] !== 1'b0) early++;
        end
        checks++;
        if (early != 0 || load_done !== 1'b1 || cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL full_done: early-done writes %0d done %b hold %b want 0 1 0", early, load_done, cpu_hold);
        end
        do_reload();
    endtask

    task automatic test_reset_midload();
        logic [7:0] bytes[8];
        clear_mon();
        bytes = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        foreach (bytes[i]) send_byte(bytes[i]);
        apply_reset();
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (debug_state !== ST_IDLE || cpu_hold !== 1'b1 || load_done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: state %0d hold %b done %b want %0d 1 0", debug_state, cpu_hold, load_done, ST_IDLE);
        end
        checks++;
        if (wr_data_q.size() != 1) begin
            errors++;
            $display("FAIL midreset_writes: got %0d want 1", wr_data_q.size());
        end
        clear_mon();
        tx_words = '{32'hCAFEF00D};
        exp_q    = tx_words;
        send_frame(8'd1);
        wait_end(20);
        checks++;
        if (wr_data_q.size() != 1 || (wr_data_q.size() == 1 && (wr_addr_q[0] !== 8'd0 || wr_data_q[0] !== exp_q[0]))) begin
            errors++;
            $display("FAIL midreset_fresh: count %0d want 1 write of %h at addr 00", wr_data_q.size(), exp_q[0]);
        end
        checks++;
        if (load_done !== 1'b1) begin
            errors++;
            $display("FAIL midreset_fresh_done: got %b want 1", load_done);
        end
        do_reload();
    endtask

    task automatic test_back_to_back();
        clear_mon();
        do_reload();
        checks++;
        if (debug_state !== ST_IDLE) begin
            errors++;
            $display("FAIL b2b_reload_in_idle: state %0d want %0d", debug_state, ST_IDLE);
        end
        tx_words.delete();
        for (int i = 0; i < 8; i++) tx_words.push_back($urandom());
        exp_q = tx_words;
        send_frame(8'd8);
        wait_end(20);
        checks++;
        if (wr_data_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b_write_count: got %0d want %0d", wr_data_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < wr_data_q.size(); i++) begin
            checks++;
            if (wr_addr_q[i] !== i[7:0] || wr_data_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_write_%0d: got addr %h data %h want addr %h data %h", i, wr_addr_q[i], wr_data_q[i], i[7:0], exp_q[i]);
            end
        end
        byte_in    = SYNC;
        byte_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        idle_bus();
        checks++;
        if (debug_state !== ST_DONE || load_done !== 1'b1 || byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done_ignores_bytes: state %0d done %b ready %b want %0d 1 0", debug_state, load_done, byte_ready, ST_DONE);
        end
        do_reload();
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_discard_latency();
`ifdef LOADER_CHECKSUM_EN
        test_checksum_error();
`endif
        test_full_256();
        test_reset_midload();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
